// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two byte-enabled write ports,
// same-cycle write-to-read bypass and a hardware clear sequencer.
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NRD      = 2,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_req,
   output logic                   busy,
   input  logic                   we0,
   input  logic [ADDR_W-1:0]      waddr0,
   input  logic [DATA_W/8-1:0]    wbe0,
   input  logic [DATA_W-1:0]      wdata0,
   input  logic                   we1,
   input  logic [ADDR_W-1:0]      waddr1,
   input  logic [DATA_W/8-1:0]    wbe1,
   input  logic [DATA_W-1:0]      wdata1,
   input  logic [NRD-1:0]         re,
   input  logic [NRD*ADDR_W-1:0]  raddr,
   output logic [NRD*DATA_W-1:0]  rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int          NB    = int'(DATA_W / 8);

   typedef enum logic [0:0] {StClear, StIdle} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cptr_q, cptr_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wen0, wen1;

   // Sequencer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StClear;
         cptr_q  <= '0;
      end else begin
         state_q <= state_d;
         cptr_q  <= cptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cptr_d  = cptr_q;
      unique case (state_q)
         StClear: begin
            cptr_d = cptr_q + 1'b1;
            if (&cptr_q) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (clr_req) begin
               state_d = StClear;
               cptr_d  = '0;
            end
         end
         default: begin
            state_d = StClear;
            cptr_d  = '0;
         end
      endcase
   end

   assign busy = (state_q == StClear);

   // Effective write enables; entry 0 is read-only when ZERO_REG is set
   assign wen0 = we0 && !busy && (!ZERO_REG || (waddr0 != '0));
   assign wen1 = we1 && !busy && (!ZERO_REG || (waddr1 != '0));

   // Storage has no reset; the sequencer defines its contents.
   // Port 1 lanes are scheduled after port 0 so it wins a same-lane collision.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[cptr_q] <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (wen0 && wbe0[b]) begin
               mem[waddr0][8*b +: 8] <= wdata0[8*b +: 8];
            end
         end
         for (int b = 0; b < NB; b++) begin
            if (wen1 && wbe1[b]) begin
               mem[waddr1][8*b +: 8] <= wdata1[8*b +: 8];
            end
         end
      end
   end

   // Read ports
   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] word;
      logic              rd_ok;

      assign ra    = raddr[p*ADDR_W +: ADDR_W];
      assign rd_ok = rst && !busy && re[p] && (!ZERO_REG || (ra != '0));

      // Bypass mirrors the commit order so the result equals the post-edge contents
      always_comb begin
         word = mem[ra];
         for (int b = 0; b < NB; b++) begin
            if (wen0 && wbe0[b] && (waddr0 == ra)) begin
               word[8*b +: 8] = wdata0[8*b +: 8];
            end
            if (wen1 && wbe1[b] && (waddr1 == ra)) begin
               word[8*b +: 8] = wdata1[8*b +: 8];
            end
         end
      end

      assign rdata[p*DATA_W +: DATA_W] = rd_ok ? word : '0;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the CPU core. It is the successor to the two-read/one-write file. It adds:
- a configurable number of read ports;
- two write ports with byte enables;
- byte-accurate write-to-read bypass;
- a hardware clear sequencer that zeroes the array after reset or on request.

It sits between decode (read ports) and writeback (write ports, e.g. ALU and load pipes).

## Interface
- DATA_W, 32: register width; multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2^ADDR_W entries.
- NRD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = entry 0 reads as zero and ignores writes.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr_req  in  1  one-cycle pulse; starts a full-array clear when idle.
- busy  out  1  high while the clear sequencer runs.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wbe0  in  DATA_W/8  byte enables, port 0; bit k selects bits [8k+7:8k].
- wdata0  in  DATA_W  write data, port 0.
- we1, waddr1, wbe1, wdata1: same as port 0, for write port 1.
- re  in  NRD  per-port read enable.
- raddr  in  NRD*ADDR_W  packed read addresses; port p uses [p*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  packed read data; port p uses [p*DATA_W +: DATA_W].

## Operation
- **Storage.** DEPTH x DATA_W array, no reset on the array itself. Contents are defined only after the clear sequencer has run.
- **Sequencer.**
  - States: CLEAR and IDLE, plus an ADDR_W-bit counter `cptr`.
  - Asynchronous reset forces CLEAR with cptr = 0 and busy = 1.
  - In CLEAR, each cycle writes zero to entry cptr, then increments cptr.
  - When cptr = DEPTH-1 is written, the next state is IDLE with busy = 0; cptr wraps to 0.
  - In IDLE, clr_req = 1 enters CLEAR with cptr = 0 on the next edge.
  - clr_req while busy is ignored; a clear is never restarted except by reset.
  - Reset asserted mid-clear restarts the clear from entry 0.
- **Writes** (IDLE only; ignored entirely while busy):
  - Port p with wep = 1 updates the lanes of entry waddrp where wbep = 1. Other lanes are kept.
  - wep = 1 with wbep = 0 is a no-op.
  - ZERO_REG = 1: writes to address 0 are discarded.
  - Both ports at the same address: lanes are merged; where both enable the same lane, port 1 wins.
- **Reads.** Purely combinational, per port p:
  - rst low, or busy = 1: rdata_p = 0.
  - re[p] = 0: rdata_p = 0.
  - ZERO_REG = 1 and raddr_p = 0: rdata_p = 0.
  - Otherwise rdata_p = array[raddr_p], with bypass per lane:
    - lanes enabled by port 0 (we0 = 1, waddr0 = raddr_p) take wdata0;
    - port 1 then overrides in the same way.
  - Result: rdata_p equals what the entry will hold after the edge.
- **Ports.** All NRD read ports are independent; any combination of equal addresses is legal.

## Timing
- **Read latency:** 0 cycles (combinational from raddr, re, we*, waddr*, wbe*, wdata*, busy).
- **Write latency:** committed at the rising edge where it is presented. Visible without bypass from the next cycle.
- **Clear duration:** busy is high for exactly DEPTH cycles after reset deassertion, or after the edge that samples clr_req.
- **Reset values:** busy = 1, cptr = 0, state = CLEAR, rdata = 0.

## Test plan
- **Reset clear.** Release rst, hold all inputs idle.
  - busy = 1 for exactly 32 cycles, then 0.
  - Reads of all 32 entries return 0x00000000.
- **Byte-enable write.**
  - Write 0xAABBCCDD to r5 with wbe 1111, then 0x11223344 with wbe 0101.
  - Read r5 = 0xAA22CC44.
- **Dual-write collision.** Same cycle: port 0 writes r7 = 0x12345678 with wbe 1111; port 1 writes r7 = 0x9ABCDEF0 with wbe 0011.
  - Same-cycle read of r7 = 0x1234DEF0.
  - Next-cycle read of r7 = 0x1234DEF0.
- **Zero register.**
  - Write 0xFFFFFFFF to r0 on both ports: r0 reads 0.
  - Check r0 with ZERO_REG = 0 in a second build: r0 reads 0xFFFFFFFF.
- **Clear on request plus mid-clear reset.**
  - Fill r1..r31 with nonzero data, pulse clr_req.
  - Writes during busy have no effect.
  - Assert rst at clear cycle 10; busy restarts for 32 cycles.
  - All entries read 0 afterwards.
- **Read gating.** With NRD = 4, all ports read r3 = 0x5 and re = 1011.
  - Ports 0, 1 and 3 return 0x5.
  - Port 2 returns 0.
